// File: rtl/mem_arbiter_if.sv
// Shared-memory arbiter bundle: I/D requester handshakes plus the memory port.
// slave modport is the arbiter view; master is the requester/memory environment view.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned LINE_W = 64
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_done;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic              d_done;
  logic [LINE_W-1:0] rdata;
  logic              i_gnt;
  logic              d_gnt;
  logic              mem_re;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_done, d_done, rdata, i_gnt, d_gnt, mem_re, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_done, d_done, rdata, i_gnt, d_gnt, mem_re, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises I-fill and D-fill/writeback onto one fixed-latency memory port.
// Define MEM_ARB_FAIR_EN for alternating tie-break (last_i); otherwise D wins every tie.
module mem_arbiter #(
  parameter int unsigned MEM_LATENCY = 4,
  parameter int unsigned ADDR_W      = 14,
  parameter int unsigned LINE_W      = 64
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);
  localparam int unsigned      CNT_W    = $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              i_gnt_q, i_gnt_d, d_gnt_q, d_gnt_d;
  logic              mem_re_q, mem_re_d, mem_we_q, mem_we_d;
  logic              i_done_q, i_done_d, d_done_q, d_done_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic              tie_to_d, pick_d, pick_we;

`ifdef MEM_ARB_FAIR_EN
  logic last_i_q, last_i_d;
  assign tie_to_d = last_i_q;
`else
  assign tie_to_d = 1'b1;
`endif

  assign pick_d  = bus.d_req && (!bus.i_req || tie_to_d);
  assign pick_we = pick_d && bus.d_we;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    i_gnt_d  = i_gnt_q;
    d_gnt_d  = d_gnt_q;
    mem_re_d = mem_re_q;
    mem_we_d = mem_we_q;
    i_done_d = 1'b0;
    d_done_d = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
`ifdef MEM_ARB_FAIR_EN
    last_i_d = last_i_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.i_req || bus.d_req) begin
          state_d  = BUSY;
          cnt_d    = CNT_LOAD;
          i_gnt_d  = !pick_d;
          d_gnt_d  = pick_d;
          mem_re_d = !pick_we;
          mem_we_d = pick_we;
          addr_d   = pick_d ? bus.d_addr : bus.i_addr;
          wdata_d  = bus.d_wdata;
`ifdef MEM_ARB_FAIR_EN
          last_i_d = !pick_d;
`endif
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_LAST;
        // mem_we_q doubles as the latched direction while BUSY
        if (cnt_q == CNT_LAST) begin
          state_d  = RESP;
          mem_re_d = 1'b0;
          mem_we_d = 1'b0;
          i_done_d = i_gnt_q;
          d_done_d = d_gnt_q;
          if (!mem_we_q) rdata_d = bus.mem_rdata;
        end
      end
      RESP: begin
        state_d = IDLE;
        i_gnt_d = 1'b0;
        d_gnt_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      i_gnt_q  <= 1'b0;
      d_gnt_q  <= 1'b0;
      mem_re_q <= 1'b0;
      mem_we_q <= 1'b0;
      i_done_q <= 1'b0;
      d_done_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
`ifdef MEM_ARB_FAIR_EN
      last_i_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      i_gnt_q  <= i_gnt_d;
      d_gnt_q  <= d_gnt_d;
      mem_re_q <= mem_re_d;
      mem_we_q <= mem_we_d;
      i_done_q <= i_done_d;
      d_done_q <= d_done_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
`ifdef MEM_ARB_FAIR_EN
      last_i_q <= last_i_d;
`endif
    end
  end

  assign bus.i_done    = i_done_q;
  assign bus.d_done    = d_done_q;
  assign bus.i_gnt     = i_gnt_q;
  assign bus.d_gnt     = d_gnt_q;
  assign bus.mem_re    = mem_re_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.rdata     = rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model, one DUT at MEM_LATENCY=4 and one at 1.
module tb_mem_arbiter;
  localparam int unsigned LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc   = 0;
  logic [63:0] m_rdata;
`ifdef MEM_ARB_FAIR_EN
  bit          m_last_i;
`endif

  mem_arbiter_if #(.ADDR_W(14), .LINE_W(64)) ifa ();
  mem_arbiter_if #(.ADDR_W(14), .LINE_W(64)) ifb ();

  mem_arbiter #(.MEM_LATENCY(LAT), .ADDR_W(14), .LINE_W(64)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  mem_arbiter #(.MEM_LATENCY(1),   .ADDR_W(14), .LINE_W(64)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      n_cmp++;
      if ((ifa.mem_re && ifa.mem_we) || (ifb.mem_re && ifb.mem_we)) begin
        n_err++;
        $display("FAIL strobe_excl a re/we=%b%b b re/we=%b%b, required never both 1",
                 ifa.mem_re, ifa.mem_we, ifb.mem_re, ifb.mem_we);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1);
  end

  function automatic bit tie_goes_d();
`ifdef MEM_ARB_FAIR_EN
    return m_last_i;
`else
    return 1'b1;
`endif
  endfunction

  // Entered at an IDLE negedge with requests set up; leaves at the IDLE negedge after RESP.
  task automatic serve(input logic [63:0] rd, input bit drop, output bit got_d);
    bit          d_win, ewe;
    logic [13:0] ea;
    logic [63:0] ew;
    logic [5:0]  exp_v, got_v;
    d_win = ifa.d_req && (!ifa.i_req || tie_goes_d());
    ewe   = d_win && ifa.d_we;
    ea    = d_win ? ifa.d_addr : ifa.i_addr;
    ew    = ifa.d_wdata;
    got_d = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      if (k == 1) got_d = ifa.d_gnt;
      exp_v = {!ewe, ewe, !d_win, d_win, 2'b00};
      got_v = {ifa.mem_re, ifa.mem_we, ifa.i_gnt, ifa.d_gnt, ifa.i_done, ifa.d_done};
      n_cmp++;
      if (got_v !== exp_v) begin
        n_err++;
        $display("FAIL busy_ctl k=%0d re,we,ig,dg,id,dd got %b want %b", k, got_v, exp_v);
      end
      n_cmp++;
      if (ifa.mem_addr !== ea) begin
        n_err++;
        $display("FAIL busy_addr k=%0d got %h want %h", k, ifa.mem_addr, ea);
      end
      n_cmp++;
      if (ifa.rdata !== m_rdata) begin
        n_err++;
        $display("FAIL busy_rdata k=%0d got %h want %h", k, ifa.rdata, m_rdata);
      end
      if (ewe) begin
        n_cmp++;
        if (ifa.mem_wdata !== ew) begin
          n_err++;
          $display("FAIL busy_wdata k=%0d got %h want %h", k, ifa.mem_wdata, ew);
        end
      end
      ifa.mem_rdata = (k == LAT) ? rd : {$urandom, $urandom};
      if (drop && k == 2) begin
        if (d_win) begin
          ifa.d_req = 1'b0; ifa.d_addr = 14'($urandom); ifa.d_wdata = {$urandom, $urandom};
        end else begin
          ifa.i_req = 1'b0; ifa.i_addr = 14'h0001;
        end
      end
    end
    @(negedge clk);
    if (!ewe) m_rdata = rd;
    exp_v = {2'b00, !d_win, d_win, !d_win, d_win};
    got_v = {ifa.mem_re, ifa.mem_we, ifa.i_gnt, ifa.d_gnt, ifa.i_done, ifa.d_done};
    n_cmp++;
    if (got_v !== exp_v) begin
      n_err++;
      $display("FAIL resp_ctl re,we,ig,dg,id,dd got %b want %b", got_v, exp_v);
    end
    n_cmp++;
    if (ifa.rdata !== m_rdata) begin
      n_err++;
      $display("FAIL resp_rdata got %h want %h", ifa.rdata, m_rdata);
    end
    if (d_win) ifa.d_req = 1'b0; else ifa.i_req = 1'b0;
`ifdef MEM_ARB_FAIR_EN
    m_last_i = !d_win;
`endif
    @(negedge clk);
    got_v = {ifa.mem_re, ifa.mem_we, ifa.i_gnt, ifa.d_gnt, ifa.i_done, ifa.d_done};
    n_cmp++;
    if (got_v !== 6'b0 || ifa.rdata !== m_rdata) begin
      n_err++;
      $display("FAIL idle_after ctl got %b rdata %h want 000000 rdata %h", got_v, ifa.rdata, m_rdata);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    ifa.i_req = 1'b1; ifa.d_req = 1'b1; ifa.mem_rdata = '1;
    ifb.i_req = 1'b1; ifb.mem_rdata = '1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({ifa.mem_re, ifa.mem_we, ifa.i_gnt, ifa.d_gnt, ifa.i_done, ifa.d_done} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_ctl_a got %b want 000000",
               {ifa.mem_re, ifa.mem_we, ifa.i_gnt, ifa.d_gnt, ifa.i_done, ifa.d_done});
    end
    n_cmp++;
    if (ifa.rdata !== 64'h0 || ifa.mem_addr !== 14'h0 || ifa.mem_wdata !== 64'h0) begin
      n_err++;
      $display("FAIL reset_data_a rdata %h addr %h wdata %h want all 0", ifa.rdata, ifa.mem_addr, ifa.mem_wdata);
    end
    n_cmp++;
    if ({ifb.mem_re, ifb.i_gnt, ifb.i_done} !== 3'b0 || ifb.rdata !== 64'h0) begin
      n_err++;
      $display("FAIL reset_b re,ig,id %b rdata %h want 000 and 0", {ifb.mem_re, ifb.i_gnt, ifb.i_done}, ifb.rdata);
    end
    ifa.i_req = 1'b0; ifa.d_req = 1'b0; ifb.i_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    m_rdata = '0;
`ifdef MEM_ARB_FAIR_EN
    m_last_i = 1'b0;
`endif
    @(negedge clk);
  endtask

  task automatic test_tie();
    bit got_d, exp_d;
    ifa.i_req = 1'b1; ifa.i_addr = 14'($urandom);
    ifa.d_req = 1'b1; ifa.d_we = 1'($urandom); ifa.d_addr = 14'($urandom); ifa.d_wdata = {$urandom, $urandom};
    for (int n = 0; n < 4; n++) begin
      serve({$urandom, $urandom}, 1'b0, got_d);
`ifdef MEM_ARB_FAIR_EN
      exp_d = (n % 2) == 1;
`else
      exp_d = 1'b1;
`endif
      n_cmp++;
      if (got_d !== exp_d) begin
        n_err++;
        $display("FAIL tie_order round %0d got d_side=%b want %b", n, got_d, exp_d);
      end
      if (got_d) ifa.d_req = 1'b1; else ifa.i_req = 1'b1;
    end
    ifa.d_req = 1'b0;
    serve({$urandom, $urandom}, 1'b0, got_d);
  endtask

  task automatic test_i_fill();
    bit got_d;
    ifa.i_req = 1'b1; ifa.i_addr = 14'h0123;
    serve(64'hDEADBEEF_CAFEF00D, 1'b0, got_d);
  endtask

  task automatic test_d_writeback();
    bit got_d;
    ifa.d_req = 1'b1; ifa.d_we = 1'b1; ifa.d_addr = 14'h3FFF; ifa.d_wdata = 64'h1111_2222_3333_4444;
    serve({$urandom, $urandom}, 1'b0, got_d);
  endtask

  task automatic test_drop_req();
    bit got_d;
    ifa.i_req = 1'b1; ifa.i_addr = 14'h2A5C;
    serve({$urandom, $urandom}, 1'b1, got_d);
  endtask

  task automatic test_reset_abort();
    bit got_d;
    ifa.d_req = 1'b1; ifa.d_we = 1'b0; ifa.d_addr = 14'($urandom);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({ifa.mem_re, ifa.mem_we, ifa.i_gnt, ifa.d_gnt, ifa.d_done} !== 5'b0 || ifa.rdata !== 64'h0) begin
      n_err++;
      $display("FAIL abort_state re,we,ig,dg,dd %b rdata %h want 00000 and 0",
               {ifa.mem_re, ifa.mem_we, ifa.i_gnt, ifa.d_gnt, ifa.d_done}, ifa.rdata);
    end
    rst = 1'b1; ifa.d_req = 1'b0;
    m_rdata = '0;
`ifdef MEM_ARB_FAIR_EN
    m_last_i = 1'b0;
`endif
    for (int k = 0; k < LAT + 2; k++) begin
      @(negedge clk);
      n_cmp++;
      if (ifa.d_done !== 1'b0 || ifa.mem_re !== 1'b0 || ifa.d_gnt !== 1'b0) begin
        n_err++;
        $display("FAIL abort_quiet k=%0d dd,re,dg %b want 000", k, {ifa.d_done, ifa.mem_re, ifa.d_gnt});
      end
    end
    ifa.i_req = 1'b1; ifa.i_addr = 14'($urandom);
    serve({$urandom, $urandom}, 1'b0, got_d);
  endtask

  task automatic test_random();
    bit got_d;
    for (int n = 0; n < 40; n++) begin
      if (!ifa.i_req && !ifa.d_req) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          n_cmp++;
          if ({ifa.mem_re, ifa.mem_we, ifa.i_gnt, ifa.d_gnt, ifa.i_done, ifa.d_done} !== 6'b0 ||
              ifa.rdata !== m_rdata) begin
            n_err++;
            $display("FAIL rand_idle ctl %b rdata %h want 000000 rdata %h",
                     {ifa.mem_re, ifa.mem_we, ifa.i_gnt, ifa.d_gnt, ifa.i_done, ifa.d_done}, ifa.rdata, m_rdata);
          end
        end
      end
      if (!ifa.i_req && $urandom_range(0, 1) == 1) begin
        ifa.i_req = 1'b1; ifa.i_addr = 14'($urandom);
      end
      if (!ifa.d_req && ($urandom_range(0, 1) == 1 || !ifa.i_req)) begin
        ifa.d_req = 1'b1; ifa.d_we = 1'($urandom); ifa.d_addr = 14'($urandom); ifa.d_wdata = {$urandom, $urandom};
      end
      serve({$urandom, $urandom}, $urandom_range(0, 3) == 0, got_d);
    end
    repeat (2) if (ifa.i_req || ifa.d_req) serve({$urandom, $urandom}, 1'b0, got_d);
  endtask

  task automatic test_lat1_back_to_back();
    int          r, t_done, g_now, g_prev;
    bit          g_last;
    logic [13:0] a;
    logic [63:0] rd;
    g_last = 1'b0; g_prev = 0; g_now = 0;
    for (int n = 0; n < 3; n++) begin
      a = 14'($urandom); rd = {$urandom, $urandom};
      ifb.i_req = 1'b1; ifb.i_addr = a; ifb.mem_rdata = rd;
      r = cyc; t_done = -1;
      for (int w = 0; w < 8 && t_done < 0; w++) begin
        @(negedge clk);
        if (ifb.i_gnt && !g_last) g_now = cyc;
        g_last = ifb.i_gnt;
        if (ifb.mem_re) begin
          n_cmp++;
          if (ifb.mem_addr !== a) begin
            n_err++;
            $display("FAIL lat1_addr got %h want %h", ifb.mem_addr, a);
          end
        end
        if (ifb.i_done) begin
          t_done = cyc; ifb.i_req = 1'b0;
        end
      end
      n_cmp++;
      if (t_done < 0 || t_done - r != 2) begin
        n_err++;
        $display("FAIL lat1_done_latency got %0d want 2 (-1 means no done)", (t_done < 0) ? -1 : t_done - r);
      end
      n_cmp++;
      if (ifb.rdata !== rd) begin
        n_err++;
        $display("FAIL lat1_rdata got %h want %h", ifb.rdata, rd);
      end
      if (n > 0) begin
        n_cmp++;
        if (g_now - g_prev != 3) begin
          n_err++;
          $display("FAIL lat1_gnt_spacing got %0d want 3", g_now - g_prev);
        end
      end
      g_prev = g_now;
      @(negedge clk);
      g_last = ifb.i_gnt;
    end
  endtask

  initial begin
    rst = 1'b0;
    ifa.i_req = 1'b0; ifa.i_addr = '0; ifa.d_req = 1'b0; ifa.d_we = 1'b0;
    ifa.d_addr = '0; ifa.d_wdata = '0; ifa.mem_rdata = '0;
    ifb.i_req = 1'b0; ifb.i_addr = '0; ifb.d_req = 1'b0; ifb.d_we = 1'b0;
    ifb.d_addr = '0; ifb.d_wdata = '0; ifb.mem_rdata = '0;
    test_reset();
    test_tie();
    test_i_fill();
    test_d_writeback();
    test_drop_req();
    test_reset_abort();
    test_random();
    test_lat1_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
